serial_word_feeder: RTL and testbench

Upstream feed stage for the serial pattern detector. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out bit-serially on `serial_out`, asserting `start` exactly while a valid bit is driven. The detector consumes `serial_out`/`start` directly and holds its state while `start` is low. A running count of transmitted words is kept for status.

---
 rtl/serial_word_feeder.sv | 122 ++++++++++++
 tb/tb_serial_word_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feed stage: buffers one word behind a valid/ready handshake and
// shifts it out bit-serially with a start qualifier, optionally followed by idle gap cycles.
module serial_word_feeder #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             serial_out,
    output logic             start,
    output logic             busy,
    output logic [15:0]      words_sent
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic               hold_full_reg, hold_full_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [3:0]         gap_cnt_reg, gap_cnt_next;
    logic [15:0]        words_sent_reg, words_sent_next;
    logic               engine_free;
    logic               accept;
    logic               shift_bit;

    assign par_ready  = ~hold_full_reg;
    assign accept     = par_valid & par_ready;
    assign shift_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    // Outputs depend only on registered state so the detector sees glitch-free inputs.
    assign start      = (state_reg == ST_SHIFT);
    assign serial_out = start & shift_bit;
    assign busy       = (state_reg != ST_IDLE) | hold_full_reg;
    assign words_sent = words_sent_reg;

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        words_sent_next = words_sent_reg;
        engine_free     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                engine_free = 1'b1;
            end
            ST_SHIFT: begin
                shift_next   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
                bit_cnt_next = bit_cnt_reg - 1'b1;
                if (bit_cnt_reg == '0) begin
                    words_sent_next = words_sent_reg + 16'd1;
                    if (GAP_CYCLES > 0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        state_next  = ST_IDLE;
                        engine_free = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_next = gap_cnt_reg - 4'd1;
                if (gap_cnt_reg == 4'd0) begin
                    state_next  = ST_IDLE;
                    engine_free = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A free engine with a held word overrides the IDLE choice above, which is
        // what lets back-to-back words stream with no bubble.
        if (engine_free && hold_full_reg) begin
            shift_next     = hold_reg;
            bit_cnt_next   = LAST_BIT;
            state_next     = ST_SHIFT;
            hold_full_next = 1'b0;
        end

        if (accept) begin
            hold_next      = par_data;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            words_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            words_sent_reg <= words_sent_next;
        end
    end
endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: three parameter variants, scoreboarded serial bits,
// table-driven single words plus hand sequences for streaming, gaps, reset and wrap.
module tb_serial_word_feeder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // instance 0: MSB first, no gap; 1: LSB first, no gap; 2: MSB first, 2 gap cycles
    logic [7:0]  d0, d1, d2;
    logic        v0, v1, v2;
    logic        rdy0, rdy1, rdy2, ser0, ser1, ser2, st0, st1, st2, bsy0, bsy1, bsy2;
    logic [15:0] ws0, ws1, ws2;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clock(clock), .reset(reset), .par_data(d0), .par_valid(v0), .par_ready(rdy0),
        .serial_out(ser0), .start(st0), .busy(bsy0), .words_sent(ws0));
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_l (
        .clock(clock), .reset(reset), .par_data(d1), .par_valid(v1), .par_ready(rdy1),
        .serial_out(ser1), .start(st1), .busy(bsy1), .words_sent(ws1));
    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_g (
        .clock(clock), .reset(reset), .par_data(d2), .par_valid(v2), .par_ready(rdy2),
        .serial_out(ser2), .start(st2), .busy(bsy2), .words_sent(ws2));

    int n_pass  = 0;
    int n_total = 0;
    bit exp_q0[$];
    bit exp_q1[$];
    bit exp_q2[$];
    int cnt [3];

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [7:0] bits;   // expected serial order, leftmost bit first
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic sel_ready(input int i);
        return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic sel_start(input int i);
        return (i == 0) ? st0 : (i == 1) ? st1 : st2;
    endfunction
    function automatic logic sel_ser(input int i);
        return (i == 0) ? ser0 : (i == 1) ? ser1 : ser2;
    endfunction
    function automatic logic sel_busy(input int i);
        return (i == 0) ? bsy0 : (i == 1) ? bsy1 : bsy2;
    endfunction
    function automatic logic [15:0] sel_ws(input int i);
        return (i == 0) ? ws0 : (i == 1) ? ws1 : ws2;
    endfunction

    task automatic drive(input int i, input logic [7:0] d, input logic v);
        case (i)
            0: begin d0 = d; v0 = v; end
            1: begin d1 = d; v1 = v; end
            default: begin d2 = d; v2 = v; end
        endcase
    endtask

    task automatic push_bits(input int i, input logic [7:0] bits);
        for (int b = 7; b >= 0; b--) begin
            case (i)
                0: exp_q0.push_back(bits[b]);
                1: exp_q1.push_back(bits[b]);
                default: exp_q2.push_back(bits[b]);
            endcase
        end
    endtask

    // Scoreboard: every start-high cycle pops one expected bit; idle cycles must drive 0.
    task automatic mon(input int i);
        bit e;
        int sz;
        sz = (i == 0) ? exp_q0.size() : (i == 1) ? exp_q1.size() : exp_q2.size();
        if (sel_start(i)) begin
            if (sz == 0) begin
                check($sformatf("extra_bit_%0d", i), 32'(sel_start(i)), 32'd0);
            end else begin
                case (i)
                    0: e = exp_q0.pop_front();
                    1: e = exp_q1.pop_front();
                    default: e = exp_q2.pop_front();
                endcase
                check($sformatf("serial_bit_%0d", i), 32'(sel_ser(i)), 32'(e));
            end
        end else begin
            check($sformatf("idle_serial_%0d", i), 32'(sel_ser(i)), 32'd0);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            mon(0);
            mon(1);
            mon(2);
        end
    end

    task automatic send_word(input int i, input logic [7:0] d);
        int n;
        @(negedge clock);
        drive(i, d, 1'b1);
        n = 0;
        while (!sel_ready(i) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(sel_ready(i)), 32'd1);
        @(posedge clock);
        @(negedge clock);
        drive(i, d, 1'b0);
    endtask

    task automatic wait_done(input int i, output int n_start, output int first_k);
        n_start = 0;
        first_k = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (sel_start(i)) begin
                n_start++;
                if (first_k < 0) first_k = k;
            end
            if (!sel_busy(i)) break;
        end
        if (sel_busy(i)) check("done_timeout", 32'(sel_busy(i)), 32'd0);
    endtask

    initial begin
        int ns, fk;
        logic exp_s;
        vecs[0] = '{0, 8'hB0, 8'b1011_0000};
        vecs[1] = '{0, 8'h5A, 8'b0101_1010};
        vecs[2] = '{0, 8'h0F, 8'b0000_1111};
        vecs[3] = '{1, 8'h0D, 8'b1011_0000};
        vecs[4] = '{1, 8'h01, 8'b1000_0000};
        vecs[5] = '{1, 8'h80, 8'b0000_0001};
        vecs[6] = '{2, 8'hC3, 8'b1100_0011};
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            drive(i, 8'h00, 1'b0);
        end

        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(sel_ready(i)), 32'd1);
            check("rst_start", 32'(sel_start(i)), 32'd0);
            check("rst_serial", 32'(sel_ser(i)), 32'd0);
            check("rst_busy", 32'(sel_busy(i)), 32'd0);
            check("rst_words", 32'(sel_ws(i)), 32'd0);
        end
        reset = 1'b0;

        // Single words: latency, start width, bit order, count
        for (int v = 0; v < 7; v++) begin
            push_bits(vecs[v].inst, vecs[v].bits);
            send_word(vecs[v].inst, vecs[v].data);
            check("k0_start", 32'(sel_start(vecs[v].inst)), 32'd0);
            check("k0_busy", 32'(sel_busy(vecs[v].inst)), 32'd1);
            check("k0_ready", 32'(sel_ready(vecs[v].inst)), 32'd0);
            wait_done(vecs[v].inst, ns, fk);
            cnt[vecs[v].inst]++;
            check("first_bit_latency", 32'(fk), 32'd1);
            check("start_width", 32'(ns), 32'd8);
            check("words_sent", 32'(sel_ws(vecs[v].inst)), 32'(cnt[vecs[v].inst]));
        end

        // Back-to-back with valid held, no gap: 16 contiguous start cycles
        @(negedge clock);
        d0 = 8'hA5; v0 = 1'b1;
        push_bits(0, 8'b1010_0101);
        @(negedge clock);
        check("b2b_ready_k0", 32'(rdy0), 32'd0);
        d0 = 8'h3C;
        push_bits(0, 8'b0011_1100);
        @(negedge clock);
        check("b2b_ready_k1", 32'(rdy0), 32'd1);
        check("b2b_start_k1", 32'(st0), 32'd1);
        @(negedge clock);
        v0 = 1'b0;
        check("b2b_ready_k2", 32'(rdy0), 32'd0);
        for (int k = 3; k <= 18; k++) begin
            @(negedge clock);
            check($sformatf("b2b_ready_k%0d", k), 32'(rdy0), 32'(k >= 9));
            check($sformatf("b2b_start_k%0d", k), 32'(st0), 32'(k <= 16));
        end
        cnt[0] += 2;
        check("b2b_words", 32'(ws0), 32'(cnt[0]));
        check("b2b_busy_end", 32'(bsy0), 32'd0);

        // Gap insertion: exactly two start-low cycles between words, busy held
        @(negedge clock);
        d2 = 8'h12; v2 = 1'b1;
        push_bits(2, 8'b0001_0010);
        @(negedge clock);
        d2 = 8'h34;
        push_bits(2, 8'b0011_0100);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            if (k == 2) v2 = 1'b0;
            exp_s = ((k >= 1 && k <= 8) || (k >= 11 && k <= 18));
            check($sformatf("gap_start_k%0d", k), 32'(st2), 32'(exp_s));
            check($sformatf("gap_busy_k%0d", k), 32'(bsy2), 32'(k <= 20));
        end
        cnt[2] += 2;
        check("gap_words", 32'(ws2), 32'(cnt[2]));

        // Asynchronous reset in the middle of a word
        push_bits(0, 8'hFF);
        send_word(0, 8'hFF);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        #1;
        check("mid_rst_start", 32'(st0), 32'd0);
        check("mid_rst_serial", 32'(ser0), 32'd0);
        check("mid_rst_ready", 32'(rdy0), 32'd1);
        check("mid_rst_busy", 32'(bsy0), 32'd0);
        check("mid_rst_words", 32'(ws0), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cnt[0] = 0;
        push_bits(0, 8'b0101_1010);
        send_word(0, 8'h5A);
        wait_done(0, ns, fk);
        check("post_rst_width", 32'(ns), 32'd8);
        check("post_rst_words", 32'(ws0), 32'd1);

        // Counter wrap from a forced 65535
        @(negedge clock);
        force dut_a.words_sent_reg = 16'hFFFF;
        #1 release dut_a.words_sent_reg;
        check("wrap_preload", 32'(ws0), 32'hFFFF);
        push_bits(0, 8'b1000_0001);
        send_word(0, 8'h81);
        wait_done(0, ns, fk);
        check("wrap_width", 32'(ns), 32'd8);
        check("wrap_words", 32'(ws0), 32'd0);

        repeat (2) @(negedge clock);
        check("queue0_empty", 32'(exp_q0.size()), 32'd0);
        check("queue1_empty", 32'(exp_q1.size()), 32'd0);
        check("queue2_empty", 32'(exp_q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
